// File: rtl/svd_result_collector.sv
// svd_result_collector: reassembles SVD core byte bursts into sorted singular-value magnitudes behind a small FIFO.
// Optional per-entry sign output enabled by defining SVD_SIGN_EN.
module svd_result_collector #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          svd_ready,
    input  logic [7:0]    svd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_sigma_max,
    output logic [15:0]   out_sigma_min,
    output logic [AW:0]   fifo_level,
    output logic          err_overflow,
    output logic          err_abort,
`ifdef SVD_SIGN_EN
    output logic [1:0]    out_sign,
`endif
    input  logic          clr_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CAP  = 2'd1;
    localparam logic [1:0] PROC = 2'd2;
    localparam logic [1:0] PUSH = 2'd3;
`ifdef SVD_SIGN_EN
    localparam int EW = 34;
`else
    localparam int EW = 32;
`endif
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [1:0]    state;
    logic [1:0]    bc;
    logic          ready_q;
    logic [7:0]    cap_b [4];
    logic [EW-1:0] res;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [EW-1:0] head;
    logic [15:0]   s1, s2, m1, m2;
    logic          start, full, pop, push, ovf_set, abort_set;

    function automatic logic [15:0] mag(input logic [15:0] s);
        return s[15] ? ((s == 16'h8000) ? 16'h7fff : (~s + 16'd1)) : s;
    endfunction

    assign start     = svd_ready & ~ready_q;
    assign s1        = {cap_b[1], cap_b[0]};
    assign s2        = {cap_b[3], cap_b[2]};
    assign m1        = mag(s1);
    assign m2        = mag(s2);
    assign full      = fifo_level == FULL_LVL;
    assign out_valid = fifo_level != '0;
    assign pop       = out_valid & out_ready;
    assign push      = (state == PUSH) & (~full | pop);
    assign ovf_set   = (state == PUSH) & full & ~pop;
    assign abort_set = (state == CAP) & (bc != 2'd3) & ~svd_ready;
    assign head      = mem[rptr];
    // Outputs are forced to zero while empty so they are stable and match reset values.
    assign out_sigma_max = out_valid ? head[31:16] : 16'd0;
    assign out_sigma_min = out_valid ? head[15:0]  : 16'd0;
`ifdef SVD_SIGN_EN
    assign out_sign = out_valid ? head[33:32] : 2'b00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bc      <= 2'd0;
            ready_q <= 1'b0;
            res     <= '0;
            for (int i = 0; i < 4; i++) cap_b[i] <= 8'd0;
        end else begin
            ready_q <= svd_ready;
            case (state)
                IDLE: if (start) begin
                    state <= CAP;
                    bc    <= 2'd0;
                end
                CAP: if (abort_set) begin
                    state <= IDLE;
                end else begin
                    cap_b[bc] <= svd_data;
                    bc        <= bc + 2'd1;
                    state     <= (bc == 2'd3) ? PROC : CAP;
                end
                PROC: begin
`ifdef SVD_SIGN_EN
                    res[33:32] <= {s2[15], s1[15]};
`endif
                    res[31:0] <= (m1 >= m2) ? {m1, m2} : {m2, m1};
                    state     <= PUSH;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr         <= '0;
            rptr         <= '0;
            fifo_level   <= '0;
            err_overflow <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            wptr         <= push ? wptr + 1'b1 : wptr;
            rptr         <= pop ? rptr + 1'b1 : rptr;
            fifo_level   <= fifo_level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            err_overflow <= ovf_set ? 1'b1 : clr_err ? 1'b0 : err_overflow;
            err_abort    <= abort_set ? 1'b1 : clr_err ? 1'b0 : err_abort;
        end
    end
endmodule

// File: tb/tb_svd_result_collector.sv
// tb_svd_result_collector: randomized bursts checked against a queue-based reference model.
module tb_svd_result_collector;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          svd_ready = 1'b0;
    logic [7:0]    svd_data = 8'd0;
    logic          out_ready = 1'b0;
    logic          clr_err = 1'b0;
    logic          out_valid;
    logic [15:0]   out_sigma_max, out_sigma_min;
    logic [AW:0]   fifo_level;
    logic          err_overflow, err_abort;
`ifdef SVD_SIGN_EN
    logic [1:0]    out_sign;
`endif

    int checks = 0;
    int errors = 0;
    logic [33:0] model_q[$];
    logic        m_ovf = 1'b0;

    svd_result_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .svd_ready(svd_ready), .svd_data(svd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sigma_max(out_sigma_max), .out_sigma_min(out_sigma_min),
        .fifo_level(fifo_level), .err_overflow(err_overflow), .err_abort(err_abort),
`ifdef SVD_SIGN_EN
        .out_sign(out_sign),
`endif
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] ref_entry(input logic [31:0] bytes);
        int s1, s2, m1, m2;
        s1 = int'($signed(bytes[15:0]));
        s2 = int'($signed(bytes[31:16]));
        m1 = (s1 < 0) ? -s1 : s1;
        m2 = (s2 < 0) ? -s2 : s2;
        if (m1 > 32767) m1 = 32767;
        if (m2 > 32767) m2 = 32767;
        if (m1 >= m2) return {bytes[31], bytes[15], 16'(m1), 16'(m2)};
        return {bytes[31], bytes[15], 16'(m2), 16'(m1)};
    endfunction

    // Bytes go out little-end first: b0=bytes[7:0] .. b3=bytes[31:24]; abort_at=k drops svd_ready at E_k.
    task automatic burst(input logic [31:0] bytes, input int abort_at, input bit pop_at_push);
        @(negedge clk) svd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (abort_at == i + 1) begin
                svd_ready = 1'b0;
                @(negedge clk);
                return;
            end
            svd_data = bytes[8*i +: 8];
        end
        @(negedge clk) svd_ready = 1'b0;
        @(negedge clk);
        if (pop_at_push) out_ready = 1'b1;
        @(negedge clk);
        if (pop_at_push) begin
            out_ready = 1'b0;
            if (model_q.size() > 0) void'(model_q.pop_front());
        end
        if (model_q.size() < DEPTH) model_q.push_back(ref_entry(bytes));
        else m_ovf = 1'b1;
    endtask

    task automatic drain(input string tag);
        checks++;
        if (fifo_level !== (AW+1)'(model_q.size())) begin
            errors++;
            $display("FAIL %s level: got %0d expected %0d", tag, fifo_level, model_q.size());
        end
        out_ready = 1'b1;
        while (model_q.size() > 0) begin
            checks++;
            if (out_valid !== 1'b1 || out_sigma_max !== model_q[0][31:16] || out_sigma_min !== model_q[0][15:0]) begin
                errors++;
                $display("FAIL %s head: valid=%b max=%h min=%h expected max=%h min=%h",
                         tag, out_valid, out_sigma_max, out_sigma_min, model_q[0][31:16], model_q[0][15:0]);
            end
`ifdef SVD_SIGN_EN
            checks++;
            if (out_sign !== model_q[0][33:32]) begin
                errors++;
                $display("FAIL %s sign: got %b expected %b", tag, out_sign, model_q[0][33:32]);
            end
`endif
            void'(model_q.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || fifo_level !== '0) begin
            errors++;
            $display("FAIL %s empty: valid=%b level=%0d expected 0 0", tag, out_valid, fifo_level);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, out_sigma_max, out_sigma_min, fifo_level, err_overflow, err_abort} !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b max=%h min=%h level=%0d ovf=%b abort=%b expected all 0",
                     out_valid, out_sigma_max, out_sigma_min, fifo_level, err_overflow, err_abort);
        end
`ifdef SVD_SIGN_EN
        checks++;
        if (out_sign !== 2'b00) begin
            errors++;
            $display("FAIL reset sign: got %b expected 00", out_sign);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        burst(32'h5678_1234, 0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_sigma_max !== 16'h5678 || out_sigma_min !== 16'h1234) begin
            errors++;
            $display("FAIL basic: valid=%b max=%h min=%h expected 1 5678 1234", out_valid, out_sigma_max, out_sigma_min);
        end
`ifdef SVD_SIGN_EN
        checks++;
        if (out_sign !== 2'b00) begin
            errors++;
            $display("FAIL basic sign: got %b expected 00", out_sign);
        end
`endif
        void'(model_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic pulse: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_saturate();
        burst(32'hFFFF_8000, 0, 1'b0);
        checks++;
        if (out_sigma_max !== 16'h7FFF || out_sigma_min !== 16'h0001) begin
            errors++;
            $display("FAIL saturate: max=%h min=%h expected 7fff 0001", out_sigma_max, out_sigma_min);
        end
`ifdef SVD_SIGN_EN
        checks++;
        if (out_sign !== 2'b11) begin
            errors++;
            $display("FAIL saturate sign: got %b expected 11", out_sign);
        end
`endif
        drain("saturate");
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 5; i++) burst($urandom, 0, 1'b0);
        checks++;
        if (fifo_level !== 3'd4 || err_overflow !== m_ovf || m_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overflow: level=%0d ovf=%b expected 4 1", fifo_level, err_overflow);
        end
        drain("overflow");
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        m_ovf = 1'b0;
        checks++;
        if (err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow clear: got %b expected 0", err_overflow);
        end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) burst($urandom, 0, 1'b0);
        burst($urandom, 0, 1'b1);
        checks++;
        if (fifo_level !== 3'd4 || err_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: level=%0d ovf=%b expected 4 0", fifo_level, err_overflow);
        end
        drain("full_pop");
    endtask

    task automatic test_abort();
        burst($urandom, 3, 1'b0);
        checks++;
        if (err_abort !== 1'b1 || fifo_level !== '0) begin
            errors++;
            $display("FAIL abort: abort=%b level=%0d expected 1 0", err_abort, fifo_level);
        end
        burst(32'h8001_7FFE, 0, 1'b0);
        drain("abort_next");
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        checks++;
        if (err_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort clear: got %b expected 0", err_abort);
        end
        clr_err = 1'b1;
        burst($urandom, 1, 1'b0);
        checks++;
        if (err_abort !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: abort=%b expected 1", err_abort);
        end
        @(negedge clk) clr_err = 1'b0;
        checks++;
        if (err_abort !== 1'b0) begin
            errors++;
            $display("FAIL abort reclear: got %b expected 0", err_abort);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] b;
        burst($urandom, 0, 1'b0);
        burst($urandom, 2, 1'b0);
        b = $urandom;
        @(negedge clk) svd_ready = 1'b1;
        @(negedge clk) svd_data = b[7:0];
        @(negedge clk) svd_data = b[15:8];
        @(negedge clk) rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sigma_max, out_sigma_min, fifo_level, err_overflow, err_abort} !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b max=%h min=%h level=%0d ovf=%b abort=%b expected all 0",
                     out_valid, out_sigma_max, out_sigma_min, fifo_level, err_overflow, err_abort);
        end
        model_q.delete();
        svd_ready = 1'b0;
        @(negedge clk) rst = 1'b1;
        burst(32'hC000_3FFF, 0, 1'b0);
        drain("after_reset");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                logic [31:0] b;
                b = $urandom;
                if ($urandom_range(0, 3) == 0) b[15:0] = 16'h8000;
                if ($urandom_range(0, 3) == 0) b[31:16] = b[15:0];
                burst(b, 0, 1'b0);
            end
            drain("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_overflow();
        test_full_pop();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
